// File: rtl/alu_arbiter.sv
// alu_arbiter: two requesters share one ALU through a valid/ready handshake.
// One operation in flight; the registered result is held until consumed.

module alu (
    input  logic [31:0] a_i,
    input  logic [31:0] b_i,
    input  logic [4:0]  ctrl_i,
    output logic [31:0] result_o,
    output logic [3:0]  flags_o
);
    logic        sub;
    logic [31:0] b_x;
    logic [32:0] sum;

    always_comb begin
        sub = ctrl_i[4];
        b_x = sub ? ~b_i : b_i;
        sum = {1'b0, a_i} + {1'b0, b_x} + {32'd0, sub};
        // Flags always come from the adder, whatever op is selected
        flags_o = {sum[31], (sum[31:0] == 32'd0), sum[32],
                   (a_i[31] == b_x[31]) && (sum[31] != a_i[31])};
        case (ctrl_i[3:0])
            4'd0:    result_o = sum[31:0];
            4'd1:    result_o = a_i & b_i;
            4'd2:    result_o = a_i | b_i;
            4'd3:    result_o = a_i ^ b_i;
            4'd4:    result_o = a_i << b_i[4:0];
            4'd5:    result_o = a_i >> b_i[4:0];
            4'd6:    result_o = $signed(a_i) >>> b_i[4:0];
            4'd7:    result_o = {31'd0, $signed(a_i) < $signed(b_i)};
            4'd8:    result_o = {31'd0, a_i < b_i};
            default: result_o = 32'd0;
        endcase
    end
endmodule

module alu_arbiter #(
    parameter int PRIO_MODE = 0,
    parameter int CNT_W     = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [1:0]       req_valid,
    output logic [1:0]       req_ready,
    input  logic [31:0]      req0_a,
    input  logic [31:0]      req0_b,
    input  logic [4:0]       req0_ctrl,
    input  logic [31:0]      req1_a,
    input  logic [31:0]      req1_b,
    input  logic [4:0]       req1_ctrl,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic             rsp_id,
    output logic [31:0]      rsp_result,
    output logic [3:0]       rsp_flags,
    output logic             busy,
    output logic [CNT_W-1:0] ops_done
);
    typedef enum logic [1:0] {IDLE, EXEC, RESP} state_e;

    state_e           state_q, state_d;
    logic             last_q, last_d;
    logic [31:0]      a_q, a_d;
    logic [31:0]      b_q, b_d;
    logic [4:0]       ctrl_q, ctrl_d;
    logic             id_q, id_d;
    logic [31:0]      res_q, res_d;
    logic [3:0]       flg_q, flg_d;
    logic             rid_q, rid_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic [1:0]  grant;
    logic        hs;
    logic        win;
    logic [31:0] alu_res;
    logic [3:0]  alu_flg;

    alu u_alu (
        .a_i      (a_q),
        .b_i      (b_q),
        .ctrl_i   (ctrl_q),
        .result_o (alu_res),
        .flags_o  (alu_flg)
    );

    // On a tie, requester 0 wins unless it was granted last (round-robin)
    always_comb begin
        grant = req_valid;
        if (req_valid == 2'b11) begin
            grant = ((PRIO_MODE != 0) || last_q) ? 2'b01 : 2'b10;
        end
    end

    assign req_ready  = (state_q == IDLE) ? grant : 2'b00;
    assign hs         = |req_ready;
    assign win        = req_ready[1];
    assign rsp_valid  = (state_q == RESP);
    assign busy       = (state_q != IDLE);
    assign rsp_id     = rid_q;
    assign rsp_result = res_q;
    assign rsp_flags  = flg_q;
    assign ops_done   = cnt_q;

    always_comb begin
        state_d = state_q;
        last_d  = last_q;
        a_d     = a_q;
        b_d     = b_q;
        ctrl_d  = ctrl_q;
        id_d    = id_q;
        res_d   = res_q;
        flg_d   = flg_q;
        rid_d   = rid_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if (hs) begin
                    a_d     = win ? req1_a : req0_a;
                    b_d     = win ? req1_b : req0_b;
                    ctrl_d  = win ? req1_ctrl : req0_ctrl;
                    id_d    = win;
                    last_d  = win;
                    state_d = EXEC;
                end
            end
            EXEC: begin
                res_d   = alu_res;
                flg_d   = alu_flg;
                rid_d   = id_q;
                state_d = RESP;
            end
            RESP: begin
                if (rsp_ready) begin
                    cnt_d   = cnt_q + CNT_W'(1);
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            last_q  <= 1'b1;
            a_q     <= 32'd0;
            b_q     <= 32'd0;
            ctrl_q  <= 5'd0;
            id_q    <= 1'b0;
            res_q   <= 32'd0;
            flg_q   <= 4'd0;
            rid_q   <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
            a_q     <= a_d;
            b_q     <= b_d;
            ctrl_q  <= ctrl_d;
            id_q    <= id_d;
            res_q   <= res_d;
            flg_q   <= flg_d;
            rid_q   <= rid_d;
            cnt_q   <= cnt_d;
        end
    end
endmodule
